upd78xx_bus_seq: RTL and testbench

//  Parametrised machine-cycle (T-state) sequencer and external bus interface for the uPD78xx core family.

---
 rtl/upd78xx_bus_seq.sv | 262 ++++++++++++++++++++++++++
 tb/tb_upd78xx_bus_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/upd78xx_bus_seq.sv
// upd78xx_bus_seq: machine-cycle (T-state) sequencer and external bus interface.
// This block turns core requests into T1..T4 bus cycles and can insert TW wait states.
// State moves on the phase-2 falling-edge enable. Bus pins update on the phase-1
// rising-edge enable, so a pin update always sees the state from before the transition.
module upd78xx_bus_seq #(
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int FETCH_T  = 4,
  parameter int MEM_T    = 3,
  parameter int WAIT_EN  = 1,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          cp1_posedge_i,
  input  logic          cp2_posedge_i,
  input  logic          cp2_negedge_i,
  input  logic          req_i,
  input  logic [1:0]    req_type_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  output logic          req_ack_o,
  output logic          rsp_valid_o,
  output logic [DW-1:0] rsp_rdata_o,
  output logic          timeout_o,
  output logic [AW-1:0] a_o,
  input  logic [DW-1:0] db_i,
  output logic [DW-1:0] db_o,
  output logic          db_oe_o,
  output logic          rdb_o,
  output logic          wrb_o,
  output logic          m1_o,
  input  logic          waitb_i,
  output logic [2:0]    tstate_o
);

  // The encodings match the TSTATE output values, so the state register drives TSTATE directly.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_TW   = 3'd7
  } state_t;

  localparam logic [1:0] TYPE_FETCH = 2'b00;
  localparam logic [1:0] TYPE_READ  = 2'b01;
  localparam logic [1:0] TYPE_WRITE = 2'b10;
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic       WAIT_ON    = (WAIT_EN != 0);
  localparam logic       FETCH_LONG = (FETCH_T == 4);
  localparam logic       MEM_LONG   = (MEM_T == 4);

  if (AW < 1 || DW < 1) begin : g_bad_width
    $error("upd78xx_bus_seq: AW and DW must be at least 1");
  end
  if (FETCH_T != 3 && FETCH_T != 4) begin : g_bad_fetch_t
    $error("upd78xx_bus_seq: FETCH_T must be 3 or 4");
  end
  if (MEM_T != 3 && MEM_T != 4) begin : g_bad_mem_t
    $error("upd78xx_bus_seq: MEM_T must be 3 or 4");
  end
  if (WAIT_EN != 0 && WAIT_EN != 1) begin : g_bad_wait_en
    $error("upd78xx_bus_seq: WAIT_EN must be 0 or 1");
  end
  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("upd78xx_bus_seq: MAX_WAIT must be in 1..255");
  end

  state_t        state_q, state_d;
  logic [1:0]    type_q, type_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic          timeout_q, timeout_d;
  logic          req_ack_q, req_ack_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] db_o_q, db_o_d;
  logic          db_oe_q, db_oe_d;
  logic          rdb_q, rdb_d;
  logic          wrb_q, wrb_d;
  logic          m1_q, m1_d;

  logic          is_fetch_s;
  logic          is_rd_s;
  logic          final_t4_s;
  logic          slot_open_s;
  logic          unused_s;

  // The phase-2 rising edge is not needed for sequencing; it is consumed here on purpose.
  assign unused_s   = cp2_posedge_i;
  assign is_fetch_s = (type_q == TYPE_FETCH);
  assign is_rd_s    = (type_q == TYPE_FETCH) || (type_q == TYPE_READ);
  assign final_t4_s = is_fetch_s ? FETCH_LONG : MEM_LONG;

  // T-state sequencing, wait/timeout handling, request accept and completion on CP2 falling edge.
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    req_ack_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    slot_open_s = 1'b0;
    if (cp2_negedge_i) begin
      case (state_q)
        S_IDLE: slot_open_s = 1'b1;
        S_T1:   state_d = S_T2;
        S_T2, S_TW: begin
          if (!WAIT_ON) begin
            state_d = S_T3;
          end else if (wait_cnt_q == MAX_WAIT_C) begin
            state_d   = S_T3;
            timeout_d = 1'b1;
          end else if (!waitb_i) begin
            state_d    = S_TW;
            wait_cnt_d = wait_cnt_q + 8'd1;
          end else begin
            state_d = S_T3;
          end
        end
        S_T3: begin
          if (final_t4_s) begin
            state_d = S_T4;
          end else begin
            rsp_valid_d = 1'b1;
            slot_open_s = 1'b1;
          end
        end
        S_T4: begin
          rsp_valid_d = 1'b1;
          slot_open_s = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
      // Completion captures read data for the cycle that just ended. Write and dummy cycles leave it untouched.
      if (rsp_valid_d && is_rd_s) begin
        rsp_rdata_d = db_i;
      end else begin
        rsp_rdata_d = rsp_rdata_q;
      end
      // An idle bus or a finishing cycle can start the next cycle with no idle T-state in between.
      if (slot_open_s && req_i) begin
        state_d    = S_T1;
        type_d     = req_type_i;
        addr_d     = req_addr_i;
        wdata_d    = req_wdata_i;
        wait_cnt_d = 8'd0;
        timeout_d  = 1'b0;
        req_ack_d  = 1'b1;
      end else if (slot_open_s) begin
        state_d = S_IDLE;
      end else begin
        slot_open_s = 1'b0;
      end
    end else begin
      state_d = state_q;
    end
  end

  // External pin updates on the CP1 rising edge, based on the current (pre-transition) state.
  always_comb begin
    a_d     = a_q;
    db_o_d  = db_o_q;
    db_oe_d = db_oe_q;
    rdb_d   = rdb_q;
    wrb_d   = wrb_q;
    m1_d    = m1_q;
    if (cp1_posedge_i) begin
      case (state_q)
        S_IDLE: begin
          db_oe_d = 1'b0;
          m1_d    = 1'b0;
        end
        S_T1: begin
          a_d     = addr_q;
          m1_d    = is_fetch_s;
          db_oe_d = 1'b0;
        end
        S_T2: begin
          if (is_rd_s) begin
            rdb_d = 1'b0;
          end else if (type_q == TYPE_WRITE) begin
            wrb_d   = 1'b0;
            db_o_d  = wdata_q;
            db_oe_d = 1'b1;
          end else begin
            rdb_d = rdb_q;
          end
        end
        S_T3: begin
          wrb_d = 1'b1;
          if (!final_t4_s) begin
            rdb_d = 1'b1;
          end else begin
            rdb_d = rdb_q;
          end
        end
        S_T4:    rdb_d = 1'b1;
        default: rdb_d = rdb_q;
      endcase
    end else begin
      rdb_d = rdb_q;
    end
  end

  // State and output registers. Reset acts immediately and abandons any cycle in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      type_q      <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= '0;
      wait_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
      req_ack_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      a_q         <= '0;
      db_o_q      <= '0;
      db_oe_q     <= 1'b0;
      rdb_q       <= 1'b1;
      wrb_q       <= 1'b1;
      m1_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      req_ack_q   <= req_ack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      a_q         <= a_d;
      db_o_q      <= db_o_d;
      db_oe_q     <= db_oe_d;
      rdb_q       <= rdb_d;
      wrb_q       <= wrb_d;
      m1_q        <= m1_d;
    end
  end

  assign req_ack_o   = req_ack_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign timeout_o   = timeout_q;
  assign a_o         = a_q;
  assign db_o        = db_o_q;
  assign db_oe_o     = db_oe_q;
  assign rdb_o       = rdb_q;
  assign wrb_o       = wrb_q;
  assign m1_o        = m1_q;
  assign tstate_o    = state_q;

endmodule

// File: tb/tb_upd78xx_bus_seq.sv
// Testbench for upd78xx_bus_seq. It uses a table of single bus cycles plus hand-written
// back-to-back and mid-cycle reset sequences. Read data is checked through a scoreboard queue.
module tb_upd78xx_bus_seq;
  localparam int MAXW = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cp1, cp2p, cp2n;
  logic        req;
  logic [1:0]  req_type;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_ack, rsp_valid, timeout;
  logic [7:0]  rsp_rdata;
  logic [15:0] a;
  logic [7:0]  db_in, db_out;
  logic        db_oe, rdb, wrb, m1, waitb;
  logic [2:0]  tstate;

  always #5 clk = ~clk;

  upd78xx_bus_seq #(.AW(16), .DW(8), .FETCH_T(4), .MEM_T(3), .WAIT_EN(1), .MAX_WAIT(MAXW)) dut (
    .clk_i(clk), .reset_i(reset), .cp1_posedge_i(cp1), .cp2_posedge_i(cp2p), .cp2_negedge_i(cp2n),
    .req_i(req), .req_type_i(req_type), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ack_o(req_ack), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .timeout_o(timeout),
    .a_o(a), .db_i(db_in), .db_o(db_out), .db_oe_o(db_oe), .rdb_o(rdb), .wrb_o(wrb), .m1_o(m1),
    .waitb_i(waitb), .tstate_o(tstate)
  );

  typedef struct {
    logic [1:0]  typ;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  dbi;
    int          nwait;
  } vec_t;

  vec_t        vecs[8];
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  last_rdata = 8'h00;
  logic [7:0]  mon_e;
  logic [15:0] m_a;
  logic        m_m1, m_rdb, m_wrb, m_dboe;
  logic [7:0]  m_dbo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each RSP_VALID pulse must match the oldest outstanding expected read data.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: RSP_VALID=1 with no outstanding cycle");
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_e));
      end
    end
  end

  task automatic tick(input logic p1, input logic p2p, input logic p2n);
    cp1 = p1; cp2p = p2p; cp2n = p2n;
    @(posedge clk);
    #1;
    cp1 = 1'b0; cp2p = 1'b0; cp2n = 1'b0;
  endtask

  task automatic model_reset();
    m_a = 16'h0000; m_m1 = 1'b0; m_rdb = 1'b1; m_wrb = 1'b1; m_dboe = 1'b0; m_dbo = 8'h00;
  endtask

  // Expected pin levels after the CP1 update inside state st.
  task automatic model_pins(input logic [2:0] st, input logic [1:0] typ, input logic [15:0] ad, input logic [7:0] wd);
    case (st)
      3'd0: begin m_dboe = 1'b0; m_m1 = 1'b0; end
      3'd1: begin m_a = ad; m_m1 = (typ == 2'b00); m_dboe = 1'b0; end
      3'd2: begin
        if (typ == 2'b00 || typ == 2'b01) m_rdb = 1'b0;
        else if (typ == 2'b10) begin m_wrb = 1'b0; m_dbo = wd; m_dboe = 1'b1; end
      end
      3'd3: begin m_wrb = 1'b1; if (typ != 2'b00) m_rdb = 1'b1; end
      3'd4: m_rdb = 1'b1;
      default: ;
    endcase
  endtask

  // One T-state: CP1 (pins checked), CP2 rise, CP2 fall with the given WAITB level.
  task automatic run_state(input string nm, input logic [2:0] st, input logic [1:0] typ,
                           input logic [15:0] ad, input logic [7:0] wd, input logic wb);
    tick(1'b1, 1'b0, 1'b0);
    model_pins(st, typ, ad, wd);
    chk(nm, 32'({a, m1, rdb, wrb, db_oe, db_out}), 32'({m_a, m_m1, m_rdb, m_wrb, m_dboe, m_dbo}));
    tick(1'b0, 1'b1, 1'b0);
    waitb = wb;
    tick(1'b0, 1'b0, 1'b1);
    waitb = 1'b1;
  endtask

  task automatic run_cycle(input int idx, input vec_t v);
    logic [2:0] seq[$];
    int tw;
    int si;
    logic wb;
    logic exp_to;
    tw = (v.nwait < MAXW) ? v.nwait : MAXW;
    exp_to = (v.nwait >= MAXW);
    seq.push_back(3'd1);
    seq.push_back(3'd2);
    for (int i = 0; i < tw; i++) seq.push_back(3'd7);
    seq.push_back(3'd3);
    if (v.typ == 2'b00) seq.push_back(3'd4);
    req = 1'b1; req_type = v.typ; req_addr = v.addr; req_wdata = v.wdata; db_in = v.dbi;
    run_state($sformatf("pins_v%0d_idle", idx), 3'd0, v.typ, v.addr, v.wdata, 1'b1);
    chk($sformatf("ack_v%0d", idx), 32'(req_ack), 32'd1);
    chk($sformatf("tstate_v%0d_t1", idx), 32'(tstate), 32'd1);
    chk($sformatf("timeout_clr_v%0d", idx), 32'(timeout), 32'd0);
    exp_q.push_back((v.typ == 2'b00 || v.typ == 2'b01) ? v.dbi : last_rdata);
    if (v.typ == 2'b00 || v.typ == 2'b01) last_rdata = v.dbi;
    req = 1'b0; req_type = ~v.typ; req_addr = ~v.addr; req_wdata = ~v.wdata;
    si = 0;
    for (int k = 0; k < seq.size(); k++) begin
      wb = 1'b1;
      if (seq[k] == 3'd2 || seq[k] == 3'd7) begin
        wb = (si < v.nwait) ? 1'b0 : 1'b1;
        si++;
      end
      run_state($sformatf("pins_v%0d_s%0d", idx, k), seq[k], v.typ, v.addr, v.wdata, wb);
      if (k < seq.size() - 1) begin
        chk($sformatf("tstate_v%0d_s%0d", idx, k + 1), 32'({rsp_valid, tstate}), 32'({1'b0, seq[k + 1]}));
      end else begin
        chk($sformatf("done_v%0d", idx), 32'({rsp_valid, tstate}), 32'({1'b1, 3'd0}));
        chk($sformatf("timeout_v%0d", idx), 32'(timeout), 32'(exp_to));
      end
    end
    run_state($sformatf("pins_v%0d_after", idx), 3'd0, v.typ, v.addr, v.wdata, 1'b1);
    chk($sformatf("rsp_count_v%0d", idx), 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    vecs[0] = '{typ: 2'b00, addr: 16'h1234, wdata: 8'h00, dbi: 8'hA5, nwait: 0};
    vecs[1] = '{typ: 2'b10, addr: 16'h00FF, wdata: 8'h5A, dbi: 8'h3C, nwait: 0};
    vecs[2] = '{typ: 2'b01, addr: 16'h8001, wdata: 8'h00, dbi: 8'h77, nwait: 2};
    vecs[3] = '{typ: 2'b01, addr: 16'h4000, wdata: 8'h00, dbi: 8'hC3, nwait: 5};
    vecs[4] = '{typ: 2'b11, addr: 16'h2222, wdata: 8'hEE, dbi: 8'h99, nwait: 0};
    vecs[5] = '{typ: 2'b00, addr: 16'hABCD, wdata: 8'h00, dbi: 8'h5E, nwait: 1};
    vecs[6] = '{typ: 2'b10, addr: 16'h0F0F, wdata: 8'h81, dbi: 8'h18, nwait: 1};
    vecs[7] = '{typ: 2'b01, addr: 16'hFFFE, wdata: 8'h00, dbi: 8'h42, nwait: 3};

    reset = 1'b1; cp1 = 1'b0; cp2p = 1'b0; cp2n = 1'b0; req = 1'b0; req_type = 2'b00;
    req_addr = 16'h0000; req_wdata = 8'h00; db_in = 8'h00; waitb = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pins", 32'({a, m1, rdb, wrb, db_oe, db_out}), 32'({m_a, m_m1, m_rdb, m_wrb, m_dboe, m_dbo}));
    chk("reset_status", 32'({req_ack, rsp_valid, timeout, tstate, rsp_rdata}), 32'({1'b0, 1'b0, 1'b0, 3'd0, 8'h00}));
    reset = 1'b0;
    tick(1'b0, 1'b0, 1'b1);
    chk("idle_no_req", 32'({req_ack, tstate}), 32'({1'b0, 3'd0}));

    for (int i = 0; i < 8; i++) run_cycle(i, vecs[i]);

    // Back-to-back: a fetch, then a read that is already requested when the fetch ends.
    req = 1'b1; req_type = 2'b00; req_addr = 16'h1000; req_wdata = 8'h00; db_in = 8'h11;
    run_state("b2b_idle", 3'd0, 2'b00, 16'h1000, 8'h00, 1'b1);
    chk("b2b_ack1", 32'({req_ack, tstate}), 32'({1'b1, 3'd1}));
    exp_q.push_back(8'h11);
    req_type = 2'b01; req_addr = 16'h2000;
    run_state("b2b_f_t1", 3'd1, 2'b00, 16'h1000, 8'h00, 1'b1);
    run_state("b2b_f_t2", 3'd2, 2'b00, 16'h1000, 8'h00, 1'b1);
    run_state("b2b_f_t3", 3'd3, 2'b00, 16'h1000, 8'h00, 1'b1);
    chk("b2b_t4", 32'(tstate), 32'd4);
    run_state("b2b_f_t4", 3'd4, 2'b00, 16'h1000, 8'h00, 1'b1);
    chk("b2b_same_clk", 32'({req_ack, rsp_valid, tstate}), 32'({1'b1, 1'b1, 3'd1}));
    exp_q.push_back(8'h22);
    last_rdata = 8'h22;
    db_in = 8'h22; req = 1'b0;
    run_state("b2b_r_t1", 3'd1, 2'b01, 16'h2000, 8'h00, 1'b1);
    run_state("b2b_r_t2", 3'd2, 2'b01, 16'h2000, 8'h00, 1'b1);
    run_state("b2b_r_t3", 3'd3, 2'b01, 16'h2000, 8'h00, 1'b1);
    chk("b2b_done", 32'({rsp_valid, tstate}), 32'({1'b1, 3'd0}));
    run_state("b2b_after", 3'd0, 2'b01, 16'h2000, 8'h00, 1'b1);
    chk("b2b_rsp_count", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a wait state: the cycle is abandoned with no response.
    req = 1'b1; req_type = 2'b01; req_addr = 16'h3333; db_in = 8'h66;
    run_state("rst_idle", 3'd0, 2'b01, 16'h3333, 8'h00, 1'b1);
    exp_q.push_back(8'h66);
    req = 1'b0;
    run_state("rst_t1", 3'd1, 2'b01, 16'h3333, 8'h00, 1'b1);
    run_state("rst_t2", 3'd2, 2'b01, 16'h3333, 8'h00, 1'b0);
    chk("rst_in_tw", 32'(tstate), 32'd7);
    tick(1'b1, 1'b0, 1'b0);
    chk("rst_rdb_low_tw", 32'(rdb), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    last_rdata = 8'h00;
    model_reset();
    chk("rst_async_pins", 32'({a, m1, rdb, wrb, db_oe, db_out}), 32'({m_a, m_m1, m_rdb, m_wrb, m_dboe, m_dbo}));
    chk("rst_async_status", 32'({req_ack, rsp_valid, timeout, tstate, rsp_rdata}), 32'({1'b0, 1'b0, 1'b0, 3'd0, 8'h00}));
    waitb = 1'b1;
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    #3;
    reset = 1'b0;
    rv = '{typ: 2'b01, addr: 16'h5A5A, wdata: 8'h00, dbi: 8'hD2, nwait: 0};
    run_cycle(8, rv);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
